// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler for a single CAN node: holds host-loaded frames,
// offers the lowest-ID pending frame and tracks it through arbitration, retry and completion.
module can_tx_scheduler #(
   parameter int NUM_MB    = 4,
   parameter int ID_SIZE   = 11,
   parameter int DATA_SIZE = 64,
   parameter int RETRY_W   = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [$clog2(NUM_MB)-1:0] wr_idx,
   input  logic [ID_SIZE-1:0]        wr_id,
   input  logic [DATA_SIZE-1:0]      wr_data,
   input  logic [NUM_MB-1:0]         abort,
   input  logic                      node_data_in_req,
   input  logic                      node_retransmit,
   input  logic                      node_tx_done,
   input  logic                      node_arb_lost,
   input  logic                      node_bus_off,
   output logic [DATA_SIZE-1:0]      tx_packet,
   output logic [ID_SIZE-1:0]        tx_id,
   output logic [NUM_MB-1:0]         pending,
   output logic [NUM_MB-1:0]         in_flight,
   output logic [NUM_MB-1:0]         done_pulse,
   output logic [NUM_MB-1:0]         fail_pulse,
   output logic                      wr_err,
   output logic [RETRY_W-1:0]        retry_cnt
);

   localparam int IDX_W = $clog2(NUM_MB);

   typedef enum logic [2:0] {IDLE, SELECT, OFFER, IN_FLIGHT, BUS_OFF} state_t;

   state_t               state;
   logic [ID_SIZE-1:0]   mb_id   [NUM_MB];
   logic [DATA_SIZE-1:0] mb_data [NUM_MB];
   logic [IDX_W-1:0]     sel_idx;
   logic                 retx_d;

   logic [NUM_MB-1:0]    abort_hit;
   logic [NUM_MB-1:0]    eligible;
   logic [NUM_MB-1:0]    pending_base;
   logic                 best_found;
   logic [IDX_W-1:0]     best_idx;
   logic [ID_SIZE-1:0]   best_id;
   logic                 handoff;
   logic                 wr_ok;
   logic                 sel_written;
   logic                 best_written;

   // The offered mailbox counts as in flight on the handoff edge, so a write racing
   // the node's latch is refused rather than silently replacing the frame on the bus.
   always_comb begin
      abort_hit = abort & pending & ~in_flight;
      eligible  = pending & ~abort_hit;
      best_found = 1'b0;
      best_idx   = '0;
      best_id    = '0;
      for (int k = 0; k < NUM_MB; k++) begin
         if (eligible[k] && (!best_found || mb_id[k] < best_id)) begin
            best_found = 1'b1;
            best_idx   = IDX_W'(k);
            best_id    = mb_id[k];
         end
      end
      handoff = (state == OFFER) && node_data_in_req && !abort_hit[sel_idx];
      wr_ok = wr_en && (wr_data != '0) && (int'(wr_idx) < NUM_MB) && !in_flight[wr_idx]
              && !abort[wr_idx] && !(handoff && (wr_idx == sel_idx))
              && !node_bus_off && (state != BUS_OFF);
      sel_written  = wr_ok && (wr_idx == sel_idx);
      best_written = wr_ok && (wr_idx == best_idx);
      pending_base = (pending & ~abort_hit) | (wr_ok ? (NUM_MB'(1) << wr_idx) : '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         sel_idx    <= '0;
         retx_d     <= 1'b0;
         tx_packet  <= '0;
         tx_id      <= '0;
         pending    <= '0;
         in_flight  <= '0;
         done_pulse <= '0;
         fail_pulse <= '0;
         wr_err     <= 1'b0;
         retry_cnt  <= '0;
         for (int k = 0; k < NUM_MB; k++) begin
            mb_id[k]   <= '0;
            mb_data[k] <= '0;
         end
      end else begin
         done_pulse <= '0;
         fail_pulse <= '0;
         wr_err     <= wr_en && !wr_ok;
         retx_d     <= node_retransmit;
         if (node_bus_off || state == BUS_OFF) begin
            if (state != BUS_OFF) fail_pulse <= pending;
            pending   <= '0;
            in_flight <= '0;
            tx_packet <= '0;
            tx_id     <= '0;
            state     <= BUS_OFF;
         end else begin
            if (wr_ok) begin
               mb_id[wr_idx]   <= wr_id;
               mb_data[wr_idx] <= wr_data;
            end
            fail_pulse <= abort_hit;
            pending    <= pending_base;
            case (state)
               IDLE: begin
                  tx_packet <= '0;
                  tx_id     <= '0;
                  if (|pending) state <= SELECT;
               end
               // A write landing on the winner this cycle would leave a stale offer, so pick again.
               SELECT: begin
                  if (!best_found) begin
                     state <= IDLE;
                  end else if (!best_written) begin
                     sel_idx   <= best_idx;
                     tx_packet <= mb_data[best_idx];
                     tx_id     <= mb_id[best_idx];
                     state     <= OFFER;
                  end
               end
               OFFER: begin
                  if (handoff) begin
                     in_flight <= NUM_MB'(1) << sel_idx;
                     retry_cnt <= '0;
                     state     <= IN_FLIGHT;
                  end else if (!best_found || best_idx != sel_idx || sel_written) begin
                     tx_packet <= '0;
                     tx_id     <= '0;
                     state     <= SELECT;
                  end
               end
               IN_FLIGHT: begin
                  if (node_tx_done) begin
                     done_pulse <= NUM_MB'(1) << sel_idx;
                     pending    <= pending_base & ~(NUM_MB'(1) << sel_idx);
                     in_flight  <= '0;
                     tx_packet  <= '0;
                     tx_id      <= '0;
                     state      <= IDLE;
                  end else if (node_arb_lost) begin
                     in_flight <= '0;
                     tx_packet <= '0;
                     tx_id     <= '0;
                     state     <= SELECT;
                  end else if (node_retransmit && !retx_d && retry_cnt != '1) begin
                     retry_cnt <= retry_cnt + RETRY_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
